// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, absorbs RAM read latency, holds the IR.
// Optional retired-instruction counter enabled by defining IFU_INSTR_COUNT_EN.
module instr_fetch_unit #(
    parameter int ADDR_W     = 9,
    parameter int INSTR_W    = 16,
    parameter int OPC_W      = 6,
    parameter int JUMPZ_OPC  = 52,
    parameter int JUMPNZ_OPC = 47,
    parameter int HALT_OPC   = 46,
    parameter int LAST_ADDR  = 200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [ADDR_W-1:0]        pc_addr,
    input  logic [INSTR_W-1:0]       instr_in,
    output logic [OPC_W-1:0]         ir_opcode,
    output logic [INSTR_W-OPC_W-1:0] ir_operand,
    output logic                     ir_valid,
    input  logic                     exec_done,
    input  logic                     z_flag,
    output logic                     halted,
    output logic                     pc_fault
`ifdef IFU_INSTR_COUNT_EN
    ,
    output logic [15:0]              retired_cnt
`endif
);

    localparam logic [OPC_W-1:0]  JZ   = OPC_W'(JUMPZ_OPC);
    localparam logic [OPC_W-1:0]  JNZ  = OPC_W'(JUMPNZ_OPC);
    localparam logic [OPC_W-1:0]  HLT  = OPC_W'(HALT_OPC);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] target;
    logic              taken;
    logic              target_bad;
    logic              at_last;

    // Branch target is the low operand bits; the top operand bit is ignored
    assign target     = ir_operand[ADDR_W-1:0];
    assign taken      = ((ir_opcode == JZ) && z_flag) ||
                        ((ir_opcode == JNZ) && !z_flag);
    assign target_bad = target > LAST;
    assign at_last    = pc_addr == LAST;

    // Fetch/execute sequencer with registered PC, IR and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc_addr    <= '0;
            ir_opcode  <= '0;
            ir_operand <= '0;
            ir_valid   <= 1'b0;
            halted     <= 1'b0;
            pc_fault   <= 1'b0;
`ifdef IFU_INSTR_COUNT_EN
            retired_cnt <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pc_addr <= '0;
                        state   <= S_ISSUE;
`ifdef IFU_INSTR_COUNT_EN
                        retired_cnt <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    ir_opcode  <= instr_in[INSTR_W-1:INSTR_W-OPC_W];
                    ir_operand <= instr_in[INSTR_W-OPC_W-1:0];
                    ir_valid   <= 1'b1;
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_done) begin
                        ir_valid <= 1'b0;
`ifdef IFU_INSTR_COUNT_EN
                        if (retired_cnt != 16'hFFFF)
                            retired_cnt <= retired_cnt + 16'd1;
`endif
                        if (ir_opcode == HLT) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else if (taken) begin
                            if (target_bad) begin
                                pc_fault <= 1'b1;
                                halted   <= 1'b1;
                                state    <= S_HALT;
                            end else begin
                                pc_addr <= target;
                                state   <= S_ISSUE;
                            end
                        end else if (at_last) begin
                            pc_fault <= 1'b1;
                            halted   <= 1'b1;
                            state    <= S_HALT;
                        end else begin
                            pc_addr <= pc_addr + 1'b1;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc_addr <= '0;
                        halted  <= 1'b0;
                        state   <= S_ISSUE;
`ifdef IFU_INSTR_COUNT_EN
                        retired_cnt <= '0;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed program walks plus randomized programs
// checked every cycle against an instruction-level reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  pc_addr;
    logic [15:0] instr_in = '0;
    logic [5:0]  ir_opcode;
    logic [9:0]  ir_operand;
    logic        ir_valid;
    logic        exec_done = 1'b0;
    logic        z_flag = 1'b0;
    logic        halted;
    logic        pc_fault;
`ifdef IFU_INSTR_COUNT_EN
    logic [15:0] retired_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [512];

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pc_addr    (pc_addr),
        .instr_in   (instr_in),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_valid   (ir_valid),
        .exec_done  (exec_done),
        .z_flag     (z_flag),
        .halted     (halted),
        .pc_fault   (pc_fault)
`ifdef IFU_INSTR_COUNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction RAM with one-cycle registered read
    always @(posedge clk) instr_in <= mem[pc_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: running flag, current PC, cycles since fetch issue
    bit          m_run;
    bit          m_halted;
    bit          m_fault;
    int          m_pc;
    int          m_age;
    logic [5:0]  m_op;
    logic [9:0]  m_opr;
    bit          m_valid;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0; m_halted <= 0; m_fault <= 0; m_pc <= 0;
            m_age <= 0; m_op <= '0; m_opr <= '0; m_valid <= 0; m_cnt <= 0;
        end else if (!m_run) begin
            if (start) begin
                m_run <= 1; m_halted <= 0; m_pc <= 0; m_age <= 0; m_cnt <= 0;
            end
        end else if (m_age < 2) begin
            if (m_age == 1) begin
                m_op    <= mem[m_pc][15:10];
                m_opr   <= mem[m_pc][9:0];
                m_valid <= 1;
            end
            m_age <= m_age + 1;
        end else if (exec_done) begin
            automatic int  tgt = int'(m_opr) % 512;
            automatic bit  tk = (m_op == 6'd52 && z_flag) ||
                                (m_op == 6'd47 && !z_flag);
            m_valid <= 0;
            m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            if (m_op == 6'd46) begin
                m_run <= 0; m_halted <= 1;
            end else if (tk && tgt > 200) begin
                m_run <= 0; m_halted <= 1; m_fault <= 1;
            end else if (tk) begin
                m_pc <= tgt; m_age <= 0;
            end else if (m_pc == 200) begin
                m_run <= 0; m_halted <= 1; m_fault <= 1;
            end else begin
                m_pc <= m_pc + 1; m_age <= 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pc_addr", 32'(pc_addr), 32'(m_pc));
            chk("ir_valid", 32'(ir_valid), 32'(m_valid));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("pc_fault", 32'(pc_fault), 32'(m_fault));
            chk("ir_opcode", 32'(ir_opcode), 32'(m_op));
            chk("ir_operand", 32'(ir_operand), 32'(m_opr));
`ifdef IFU_INSTR_COUNT_EN
            chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        exec_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("wait_ir_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic exec(input bit z);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            exec_done = 1'b1;
            z_flag = z;
            @(negedge clk);
            exec_done = 1'b0;
        end
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 512; i++) mem[i] = w;
    endtask

    initial begin
        bit ok;
        fill(16'h0800);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc", 32'(pc_addr), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(pc_fault), 32'd0);
        chk("rst_opcode", 32'(ir_opcode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line CLAC stream with exec_done held high
        exec_done = 1'b1;
        pulse_start();
        wait_valid(ok);
        chk("t1_opcode", 32'(ir_opcode), 32'd2);
        chk("t1_pc0", 32'(pc_addr), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_pc1", 32'(pc_addr), 32'd1);
        chk("t1_valid", 32'(ir_valid), 32'd1);
        repeat (3) @(negedge clk);
        chk("t1_pc2", 32'(pc_addr), 32'd2);
        exec_done = 1'b0;
        do_reset();

        // Branch resolution and halt/restart
        mem[0]   = {6'd52, 10'd179};
        mem[179] = {6'd52, 10'd179};
        mem[180] = {6'd47, 10'd63};
        mem[63]  = {6'd47, 10'd63};
        mem[64]  = {6'd52, 10'd185};
        mem[185] = {6'd46, 10'd0};
        pulse_start();
        exec(1); chk("t2_jz_taken", 32'(pc_addr), 32'd179);
        exec(0); chk("t2_jz_fall", 32'(pc_addr), 32'd180);
        exec(0); chk("t3_jnz_taken", 32'(pc_addr), 32'd63);
        exec(1); chk("t3_jnz_fall", 32'(pc_addr), 32'd64);
        exec(1); chk("t4_to185", 32'(pc_addr), 32'd185);
        exec(1);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_valid", 32'(ir_valid), 32'd0);
        chk("t4_opc_hold", 32'(ir_opcode), 32'd46);
`ifdef IFU_INSTR_COUNT_EN
        chk("t4_cnt6", 32'(retired_cnt), 32'd6);
`endif
        repeat (3) @(negedge clk);
        pulse_start();
        chk("t4_restart_halted", 32'(halted), 32'd0);
        chk("t4_restart_pc", 32'(pc_addr), 32'd0);
`ifdef IFU_INSTR_COUNT_EN
        chk("t4_cnt_clr", 32'(retired_cnt), 32'd0);
`endif
        do_reset();

        // Fault on running past the last address
        fill(16'h0800);
        mem[0] = {6'd52, 10'd200};
        pulse_start();
        exec(1); chk("t5_to200", 32'(pc_addr), 32'd200);
        exec(0);
        chk("t5_fault", 32'(pc_fault), 32'd1);
        chk("t5_halted", 32'(halted), 32'd1);
        do_reset();

        // Fault on out-of-range jump target; top operand bit ignored
        mem[0] = {6'd52, 10'd532};
        mem[20] = {6'd52, 10'd300};
        pulse_start();
        exec(1); chk("t5_bit9_ignored", 32'(pc_addr), 32'd20);
        exec(1);
        chk("t5_tgt_fault", 32'(pc_fault), 32'd1);
        chk("t5_tgt_halted", 32'(halted), 32'd1);
        do_reset();

        // Asynchronous reset while capturing at PC 57
        fill(16'h0800);
        mem[4] = {6'd52, 10'd57};
        pulse_start();
        repeat (4) exec(0);
        exec(1);
        chk("t6_pc57", 32'(pc_addr), 32'd57);
`ifdef IFU_INSTR_COUNT_EN
        chk("t6_cnt5", 32'(retired_cnt), 32'd5);
`endif
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pc_clr", 32'(pc_addr), 32'd0);
        chk("t6_opc_clr", 32'(ir_opcode), 32'd0);
        chk("t6_opr_clr", 32'(ir_operand), 32'd0);
        chk("t6_valid_clr", 32'(ir_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        wait_valid(ok);
        chk("t6_refetch_pc", 32'(pc_addr), 32'd0);
        chk("t6_refetch_opc", 32'(ir_opcode), 32'd2);

        // Randomized programs and control-unit timing
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int i = 0; i < 512; i++) begin
                automatic int r = $urandom_range(0, 19);
                automatic logic [5:0] op;
                automatic logic [9:0] opr;
                if (r < 4) op = 6'd52;
                else if (r < 8) op = 6'd47;
                else if (r == 8) op = 6'd46;
                else begin
                    op = 6'($urandom_range(0, 63));
                    if (op == 6'd46 || op == 6'd47 || op == 6'd52) op = 6'd2;
                end
                if ($urandom_range(0, 4) != 0)
                    opr = 10'($urandom_range(0, 200)) |
                          (10'($urandom_range(0, 1)) << 9);
                else
                    opr = 10'($urandom_range(0, 1023));
                mem[i] = {op, opr};
            end
            for (int c = 0; c < 600; c++) begin
                start = ($urandom_range(0, 5) == 0);
                exec_done = $urandom_range(0, 1) != 0;
                z_flag = $urandom_range(0, 1) != 0;
                @(negedge clk);
            end
            start = 1'b0;
            exec_done = 1'b0;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
